ddf_tag_demux_2f: RTL and testbench
===================================

Name: ddf_tag_demux_2f

Overview:
- Consumer end of the 2-flow DDF accumulator output stream.
- Each input word is `{tag, payload}`: tag (MSB) selects flow 0/1; the payload is the accumulated sum.
- Strips the tag and routes the payload to one of two per-flow output FIFOs.
- A 2-entry buffer per flow lets a stalled flow absorb words without immediately blocking the other.

Parameters:
- WIDTH, 33, input word width including tag bit; payload width is WIDTH-1.
- CNT_WIDTH, 16, width of per-flow delivered-word counters.

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_empty  input  1  input FIFO empty; in_data valid when 0 (first-word-fall-through).
- in_data  input  WIDTH  `{tag, payload}`.
- in_read  output  1  pop input FIFO this cycle; data captured at this edge.
- out0_full  input  1  flow-0 output FIFO full.
- out0_wr  output  1  write strobe, flow 0.
- out0_data  output  WIDTH-1  payload, flow 0.
- out1_full  input  1  flow-1 output FIFO full.
- out1_wr  output  1  write strobe, flow 1.
- out1_data  output  WIDTH-1  payload, flow 1.
- cnt0  output  CNT_WIDTH  words written to flow 0 since reset.
- cnt1  output  CNT_WIDTH  words written to flow 1 since reset.
- busy  output  1  any buffer non-empty.

Behaviour:
- Reset (rst=0, async):
  - Both buffers are emptied (occupancy 0, pointers 0); cnt0=cnt1=0.
  - in_read=0, out0_wr=out1_wr=0, out0_data=out1_data=0, busy=0.
  - Reset asserted mid-operation discards all buffered words; no write strobe is issued after reset asserts.
- Buffer per flow:
  - 2-entry circular buffer with occupancy 0..2.
  - Head data drives outX_data; outX_data=0 when occupancy is 0.
- Pop: outX_wr = (occX!=0) & ~outX_full. The head advances at the edge where outX_wr=1.
- Accept:
  - tag = in_data[WIDTH-1]; T = flow selected by tag.
  - in_read = ~in_empty & (occT<2 | popT).
  - On accept, in_data[WIDTH-2:0] is written at the tail of buffer T.
  - in_read is combinational from in_empty, in_data, occupancies and full inputs.
- Head-of-line rule:
  - If the head word targets a full buffer, in_read=0. The input stalls even if the other flow has space, which preserves global order.
  - Words are never reordered within a flow.
- Simultaneous push and pop on the same flow: occupancy is unchanged. Pushing into a buffer with occupancy 2 is legal only because of that same-cycle pop.
- Latency: a word accepted at edge N can appear as outT_wr=1 in cycle N+1 (one register stage). No combinational path from in_data to outX_data.
- Throughput: 1 word/cycle sustained when the destination is not full.
- Counters: cntX increments at each edge where outX_wr=1 and wraps modulo 2^CNT_WIDTH. From all-ones it returns to 0 with no sticky flag.
- busy = (occ0!=0) | (occ1!=0).
- in_empty=1: in_read=0 regardless of in_data (X-tolerant).
- Both outputs may write in the same cycle.

Decomposition:
- Shared Verilog header `ddf_defs.vh`:
  - TAG_FLOW0=0, TAG_FLOW1=1.
  - Default WIDTH (33) and tag-bit position macro, also used by DDF_1P_2F.
- Sub-module `ddf_flow_buf`:
  - Parameterised 2-entry buffer with push/pop/data/occupancy.
  - Instantiated twice; owns its pointers and the flow's counter.
- Top level: tag decode, accept logic, busy.

Test Plan:
1. Reset then stream `{1'b0,32'd5}`, `{1'b1,32'd9}`, `{1'b0,32'd7}`, outputs never full -> out0 gets 5,7 and out1 gets 9; each write is one cycle after its read; cnt0=2, cnt1=1; busy=0 at end.
2. Hold out0_full=1 and feed three flow-0 words 1,2,3 -> first two accepted, in_read=0 on the third. Release full -> out0 writes 1,2,3 in order on consecutive cycles.
3. out0_full=1 with buffer 0 at occupancy 2, head word flow 0, next word flow 1 -> in_read stays 0 and out1_wr stays 0 (order preserved). Release -> both delivered.
4. Buffer 1 at occupancy 2, out1_full=0 and a new flow-1 word at head -> in_read=1 and out1_wr=1 in the same cycle; occupancy stays 2; sustained 1 word/cycle over 20 words.
5. Preload cnt0 near wrap (CNT_WIDTH=4, 15 writes) then one more flow-0 write -> cnt0 reads 0.
6. Assert rst=0 asynchronously while both buffers are occupied -> outputs, counters and busy go to 0 immediately (before the next edge); no write strobe after rst=0; normal operation resumes after release.

Source files
------------

// File: rtl/ddf_tag_demux_2f_pkg.sv
// Shared constants for the 2-flow DDF tag demultiplexer: tag encodings,
// default widths and the tag-bit position helper.
package ddf_tag_demux_2f_pkg;

  localparam logic TagFlow0 = 1'b0;
  localparam logic TagFlow1 = 1'b1;

  localparam int unsigned DefWidth    = 33;
  localparam int unsigned DefCntWidth = 16;

  typedef logic [1:0] occ_t;

  localparam occ_t OccFull = 2'd2;

  // Tag sits in the MSB of the {tag, payload} word.
  function automatic int unsigned tag_bit(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/ddf_tag_demux_2f_if.sv
// Bus bundle of the tag demux: input FIFO side, two output FIFO sides, status.
interface ddf_tag_demux_2f_if #(
  parameter int unsigned WIDTH     = 33,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 in_empty;
  logic [WIDTH-1:0]     in_data;
  logic                 in_read;
  logic                 out0_full;
  logic                 out0_wr;
  logic [WIDTH-2:0]     out0_data;
  logic                 out1_full;
  logic                 out1_wr;
  logic [WIDTH-2:0]     out1_data;
  logic [CNT_WIDTH-1:0] cnt0;
  logic [CNT_WIDTH-1:0] cnt1;
  logic                 busy;

  modport slave (
    input  in_empty, in_data, out0_full, out1_full,
    output in_read, out0_wr, out0_data, out1_wr, out1_data, cnt0, cnt1, busy
  );

  modport master (
    output in_empty, in_data, out0_full, out1_full,
    input  in_read, out0_wr, out0_data, out1_wr, out1_data, cnt0, cnt1, busy
  );

endinterface

// File: rtl/ddf_tag_demux_2f_flow_buf.sv
// 2-entry circular buffer for one flow; pops into the flow's output FIFO
// whenever it is non-empty and the FIFO is not full, and counts the pops.
module ddf_tag_demux_2f_flow_buf
  import ddf_tag_demux_2f_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DW-1:0]        push_data_i,
  input  logic                 full_i,
  output logic                 wr_o,
  output logic [DW-1:0]        data_o,
  output occ_t                 occ_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [DW-1:0]        mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  occ_t                 occ_q, occ_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pop;

  assign pop = (occ_q != 2'd0) & ~full_i;

  always_comb begin
    wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    cnt_d    = pop ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    occ_d    = occ_q;
    // Push and pop together leave occupancy unchanged, even at 2.
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_o   = pop;
  assign data_o = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign occ_o  = occ_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ddf_tag_demux_2f.sv
// Consumer end of the 2-flow DDF accumulator stream: strips the tag and
// steers each payload into a per-flow buffer, stalling in order on a full flow.
module ddf_tag_demux_2f
  import ddf_tag_demux_2f_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned CNT_WIDTH = DefCntWidth
) (
  input  logic               ck,
  input  logic               rst,
  ddf_tag_demux_2f_if.slave  bus
);

  localparam int unsigned TagBit = tag_bit(WIDTH);

  logic tag;
  logic ok0, ok1;
  logic push0, push1;
  occ_t occ0, occ1;

  assign tag = bus.in_data[TagBit];

  // A full buffer still accepts when it pops on the same edge.
  assign ok0 = (occ0 != OccFull) | bus.out0_wr;
  assign ok1 = (occ1 != OccFull) | bus.out1_wr;

  // Only the head word is inspected, so a blocked flow stalls both flows.
  assign bus.in_read = rst & ~bus.in_empty & ((tag == TagFlow1) ? ok1 : ok0);
  assign push0       = bus.in_read & (tag == TagFlow0);
  assign push1       = bus.in_read & (tag == TagFlow1);

  ddf_tag_demux_2f_flow_buf #(
    .DW        (WIDTH - 1),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_buf0 (
    .ck          (ck),
    .rst         (rst),
    .push_i      (push0),
    .push_data_i (bus.in_data[WIDTH-2:0]),
    .full_i      (bus.out0_full),
    .wr_o        (bus.out0_wr),
    .data_o      (bus.out0_data),
    .occ_o       (occ0),
    .cnt_o       (bus.cnt0)
  );

  ddf_tag_demux_2f_flow_buf #(
    .DW        (WIDTH - 1),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_buf1 (
    .ck          (ck),
    .rst         (rst),
    .push_i      (push1),
    .push_data_i (bus.in_data[WIDTH-2:0]),
    .full_i      (bus.out1_full),
    .wr_o        (bus.out1_wr),
    .data_o      (bus.out1_data),
    .occ_o       (occ1),
    .cnt_o       (bus.cnt1)
  );

  assign bus.busy = (occ0 != 2'd0) | (occ1 != 2'd0);

endmodule

// File: tb/tb_ddf_tag_demux_2f.sv
// Directed bench for ddf_tag_demux_2f: models the input FIFO as a queue and
// logs every read/write with its cycle number.
module tb_ddf_tag_demux_2f;

  localparam int unsigned W  = 33;
  localparam int unsigned CW = 4;

  logic ck;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  ddf_tag_demux_2f_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  ddf_tag_demux_2f #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0]   src[$];
  logic [W-2:0]   got0[$];
  logic [W-2:0]   got1[$];
  int             w0cyc[$];
  int             w1cyc[$];
  int             rdcyc[$];

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  always @(posedge ck) cyc <= cyc + 1;

  // Mid-cycle monitor: inputs change just after posedge, so values are stable here.
  always @(negedge ck) begin
    if (bus.in_read) rdcyc.push_back(cyc);
    if (bus.out0_wr) begin
      got0.push_back(bus.out0_data);
      w0cyc.push_back(cyc);
    end
    if (bus.out1_wr) begin
      got1.push_back(bus.out1_data);
      w1cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic t, input int unsigned p);
    return {t, 32'(p)};
  endfunction

  task automatic drive_src();
    bus.in_empty = (src.size() == 0);
    bus.in_data  = (src.size() != 0) ? src[0] : '0;
  endtask

  task automatic clear_logs();
    got0.delete(); got1.delete();
    w0cyc.delete(); w1cyc.delete(); rdcyc.delete();
  endtask

  // Ends at posedge+2 with new inputs applied and settled.
  task automatic step(input int n);
    logic rd;
    for (int i = 0; i < n; i++) begin
      @(negedge ck);
      rd = bus.in_read;
      @(posedge ck);
      if (rd && src.size() != 0) void'(src.pop_front());
      #1 drive_src();
      #1;
    end
  endtask

  initial begin
    logic ok;
    int   n0, n1;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b0;
    bus.out0_full = 1'b0;
    bus.out1_full = 1'b0;
    drive_src();
    #2;
    check("rst_in_read", bus.in_read, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cnt0", bus.cnt0, 0);
    check("rst_cnt1", bus.cnt1, 0);
    check("rst_wr", {bus.out0_wr, bus.out1_wr}, 0);
    check("rst_data", {bus.out0_data, bus.out1_data}, 0);
    @(posedge ck);
    #1 rst = 1'b1;
    #1;

    // in_empty dominates whatever sits on in_data.
    bus.in_data = mk(1'b1, 32'hFFFF_FFFF);
    #1 check("empty_no_read", bus.in_read, 0);

    // 1: basic stream, one-cycle latency.
    clear_logs();
    src.push_back(mk(0, 5)); src.push_back(mk(1, 9)); src.push_back(mk(0, 7));
    drive_src();
    step(5);
    check("t1_n0", got0.size(), 2);
    check("t1_n1", got1.size(), 1);
    check("t1_nrd", rdcyc.size(), 3);
    if (got0.size() == 2 && got1.size() == 1 && rdcyc.size() == 3) begin
      check("t1_d0a", got0[0], 5);
      check("t1_d0b", got0[1], 7);
      check("t1_d1", got1[0], 9);
      check("t1_lat0", w0cyc[0] - rdcyc[0], 1);
      check("t1_lat1", w1cyc[0] - rdcyc[1], 1);
      check("t1_lat2", w0cyc[1] - rdcyc[2], 1);
    end
    check("t1_cnt0", bus.cnt0, 2);
    check("t1_cnt1", bus.cnt1, 1);
    check("t1_busy", bus.busy, 0);

    // 2: flow 0 full absorbs two words, third stalls.
    clear_logs();
    bus.out0_full = 1'b1;
    src.push_back(mk(0, 1)); src.push_back(mk(0, 2)); src.push_back(mk(0, 3));
    drive_src();
    step(4);
    check("t2_nrd", rdcyc.size(), 2);
    check("t2_stall", bus.in_read, 0);
    check("t2_busy", bus.busy, 1);
    check("t2_nowr", got0.size(), 0);
    bus.out0_full = 1'b0;
    #1;
    check("t2_pop_rd", {bus.out0_wr, bus.in_read}, 2'b11);
    step(4);
    check("t2_n0", got0.size(), 3);
    if (got0.size() == 3) begin
      check("t2_order", {got0[0][7:0], got0[1][7:0], got0[2][7:0]}, 24'h010203);
      check("t2_consec", w0cyc[2] - w0cyc[0], 2);
    end
    check("t2_cnt0", bus.cnt0, 5);

    // 3: head-of-line stall keeps the flow-1 word behind the blocked flow-0 word.
    clear_logs();
    bus.out0_full = 1'b1;
    src.push_back(mk(0, 10)); src.push_back(mk(0, 11));
    src.push_back(mk(0, 12)); src.push_back(mk(1, 20));
    drive_src();
    step(5);
    check("t3_stall", bus.in_read, 0);
    check("t3_no_wr1", bus.out1_wr, 0);
    check("t3_n1", got1.size(), 0);
    bus.out0_full = 1'b0;
    step(6);
    check("t3_n0", got0.size(), 3);
    check("t3_n1b", got1.size(), 1);
    if (got0.size() == 3 && got1.size() == 1) begin
      check("t3_d0", got0[2], 12);
      check("t3_d1", got1[0], 20);
    end
    check("t3_cnt0", bus.cnt0, 8);
    check("t3_cnt1", bus.cnt1, 2);

    // 4: flow 1 full-then-released sustains one word per cycle at occupancy 2.
    bus.out1_full = 1'b1;
    src.push_back(mk(1, 100)); src.push_back(mk(1, 101));
    drive_src();
    step(3);
    for (int i = 102; i < 122; i++) src.push_back(mk(1, i));
    drive_src();
    clear_logs();
    bus.out1_full = 1'b0;
    #1;
    check("t4_same_cyc", {bus.in_read, bus.out1_wr}, 2'b11);
    step(20);
    check("t4_nrd", rdcyc.size(), 20);
    check("t4_nwr", got1.size(), 20);
    check("t4_busy", bus.busy, 1);
    step(3);
    check("t4_ntot", got1.size(), 22);
    ok = (got1.size() == 22);
    for (int i = 0; i < got1.size(); i++) if (got1[i] != 32'(100 + i)) ok = 1'b0;
    check("t4_order", ok, 1);
    check("t4_cnt1", bus.cnt1, 8);

    // 5: counter wrap at CNT_WIDTH=4.
    for (int i = 0; i < 7; i++) src.push_back(mk(0, 50 + i));
    drive_src();
    step(9);
    check("t5_cnt0_15", bus.cnt0, 15);
    src.push_back(mk(0, 60));
    drive_src();
    step(3);
    check("t5_cnt0_wrap", bus.cnt0, 0);

    // 6: asynchronous reset with both buffers occupied.
    bus.out0_full = 1'b1;
    bus.out1_full = 1'b1;
    src.push_back(mk(0, 1)); src.push_back(mk(1, 2)); src.push_back(mk(0, 3));
    drive_src();
    step(4);
    check("t6_busy_pre", bus.busy, 1);
    n0 = got0.size();
    n1 = got1.size();
    bus.out0_full = 1'b0;
    bus.out1_full = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("t6_wr", {bus.out0_wr, bus.out1_wr}, 0);
    check("t6_data", {bus.out0_data, bus.out1_data}, 0);
    check("t6_cnt", {bus.cnt0, bus.cnt1}, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_in_read", bus.in_read, 0);
    step(3);
    check("t6_no_wr0", got0.size(), n0);
    check("t6_no_wr1", got1.size(), n1);
    @(posedge ck);
    #1 rst = 1'b1;
    clear_logs();
    src.delete();
    src.push_back(mk(0, 42)); src.push_back(mk(1, 43));
    drive_src();
    #1;
    step(4);
    check("t6_n0", got0.size(), 1);
    check("t6_n1", got1.size(), 1);
    if (got0.size() == 1 && got1.size() == 1) begin
      check("t6_d0", got0[0], 42);
      check("t6_d1", got1[0], 43);
    end
    check("t6_cnt0", bus.cnt0, 1);
    check("t6_cnt1", bus.cnt1, 1);
    check("t6_busy_end", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
